// File: rtl/mem_byte_access_if.sv
// Request / RAM / completion bundle for the byte-serial load/store engine.
// "slave" is the engine side; "master" is the buffer + RAM side that drives
// requests and read data and observes the engine's outputs.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mem_byte_access_if #(
  parameter int ADDR_W = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic [`INST_TYPE_WIDTH-1:0] req_type;
  logic [ADDR_W-1:0]           req_addr;
  logic [`DATA_WIDTH-1:0]      req_wdata;
  logic [7:0]                  mem_din;
  logic [7:0]                  mem_dout;
  logic [ADDR_W-1:0]           mem_a;
  logic                        mem_wr;
  logic                        done_valid;
  logic [`INST_TYPE_WIDTH-1:0] done_type;
  logic [`DATA_WIDTH-1:0]      done_data;

  modport master (
    output req_valid, req_type, req_addr, req_wdata, mem_din,
    input  req_ready, mem_dout, mem_a, mem_wr, done_valid, done_type, done_data
  );

  modport slave (
    input  req_valid, req_type, req_addr, req_wdata, mem_din,
    output req_ready, mem_dout, mem_a, mem_wr, done_valid, done_type, done_data
  );
endinterface

// File: rtl/mem_byte_access.sv
// Byte-serial load/store engine: splits LB/LH/LW/LBU/LHU/SB/SH/SW requests
// into 1, 2 or 4 little-endian byte accesses on an 8-bit RAM port.
// Optional feature macro: IO_STALL_EN (hold I/O-region store bytes while the
// UART output buffer is full).
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_byte_access #(
  parameter int ADDR_W = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               io_buffer_full,
  mem_byte_access_if.slave   bus
);
  localparam int TW = `INST_TYPE_WIDTH;
  localparam int DW = `DATA_WIDTH;

  localparam logic [TW-1:0] T_LB  = TW'(1);
  localparam logic [TW-1:0] T_LH  = TW'(2);
  localparam logic [TW-1:0] T_LW  = TW'(3);
  localparam logic [TW-1:0] T_LBU = TW'(4);
  localparam logic [TW-1:0] T_LHU = TW'(5);
  localparam logic [TW-1:0] T_SB  = TW'(6);
  localparam logic [TW-1:0] T_SH  = TW'(7);
  localparam logic [TW-1:0] T_SW  = TW'(8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;        // byte count minus one
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [TW-1:0]     type_q, type_d;
  logic [DW-1:0]     data_q, data_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              done_valid_q, done_valid_d;
  logic [TW-1:0]     done_type_q, done_type_d;
  logic [DW-1:0]     done_data_q, done_data_d;
  // RAM read byte for the address of the last active cycle; survives a pause
  // even though the RAM keeps reading the held address meanwhile.
  logic [7:0]        din_hold_q, din_hold_d;
  logic              prev_rdy_q, prev_rdy_d;

  logic              req_is_load, req_is_store;
  logic [1:0]        req_last;
  logic [7:0]        byte_in;
  logic [DW-1:0]     wshift;
  logic              io_stall;

  // Decode the incoming request type into direction and byte count.
  always_comb begin
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
    req_last     = 2'd0;
    case (bus.req_type)
      T_LB, T_LBU: begin req_is_load = 1'b1;  req_last = 2'd0; end
      T_LH, T_LHU: begin req_is_load = 1'b1;  req_last = 2'd1; end
      T_LW:        begin req_is_load = 1'b1;  req_last = 2'd3; end
      T_SB:        begin req_is_store = 1'b1; req_last = 2'd0; end
      T_SH:        begin req_is_store = 1'b1; req_last = 2'd1; end
      T_SW:        begin req_is_store = 1'b1; req_last = 2'd3; end
      default:     ;
    endcase
  end

`ifdef IO_STALL_EN
  assign io_stall = (state_q == S_STORE) && (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // Next-state, address sequencing, byte capture and completion.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    type_d       = type_q;
    data_d       = data_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    done_valid_d = done_valid_q;
    done_type_d  = done_type_q;
    done_data_d  = done_data_q;
    byte_in      = prev_rdy_q ? bus.mem_din : din_hold_q;
    din_hold_d   = byte_in;
    prev_rdy_d   = rdy_in;
    wshift       = wdata_q >> {idx_q[1:0] + 2'd1, 3'b000};

    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && !flush_in) begin
            type_d  = bus.req_type;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            data_d  = '0;
            idx_d   = 3'd0;
            last_d  = req_last;
            mem_a_d = bus.req_addr;
            if (req_is_load) begin
              state_d = S_LOAD;
            end else if (req_is_store) begin
              state_d    = S_STORE;
              mem_dout_d = bus.req_wdata[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d      = S_DONE;
              done_valid_d = 1'b1;
              done_type_d  = bus.req_type;
              done_data_d  = '0;
            end
          end
        end
        S_LOAD: begin
          if (flush_in) begin
            state_d = S_IDLE;
          end else begin
            // Index k presents address k and captures the byte read for k-1.
            if (idx_q != 3'd0)
              data_d = data_q | (DW'(byte_in) << {idx_q - 3'd1, 3'b000});
            if (idx_q == ({1'b0, last_q} + 3'd1)) begin
              state_d      = S_DONE;
              done_valid_d = 1'b1;
              done_type_d  = type_q;
              done_data_d  = data_d;
            end else begin
              idx_d = idx_q + 3'd1;
              if (idx_q < {1'b0, last_q})
                mem_a_d = addr_q + ADDR_W'(idx_q + 3'd1);
            end
          end
        end
        S_STORE: begin
          if (!io_stall) begin
            if (idx_q[1:0] == last_q) begin
              state_d      = S_DONE;
              mem_wr_d     = 1'b0;
              done_valid_d = 1'b1;
              done_type_d  = type_q;
              done_data_d  = '0;
            end else begin
              idx_d      = idx_q + 3'd1;
              mem_a_d    = addr_q + ADDR_W'(idx_q + 3'd1);
              mem_dout_d = wshift[7:0];
            end
          end
        end
        default: begin
          state_d      = S_IDLE;
          done_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      last_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= '0;
      data_q       <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_type_q  <= '0;
      done_data_q  <= '0;
      din_hold_q   <= 8'd0;
      prev_rdy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      type_q       <= type_d;
      data_q       <= data_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      done_valid_q <= done_valid_d;
      done_type_q  <= done_type_d;
      done_data_q  <= done_data_d;
      din_hold_q   <= din_hold_d;
      prev_rdy_q   <= prev_rdy_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q && rdy_in && !io_stall;
  assign bus.done_valid = done_valid_q;
  assign bus.done_type  = done_type_q;
  assign bus.done_data  = done_data_q;
endmodule

// File: tb/tb_mem_byte_access.sv
// Directed testbench for mem_byte_access: byte sequencing, latency, pause,
// flush, address wrap and reset behaviour against a registered-read RAM.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_byte_access;
  localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic iofull = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_byte_access_if #(.ADDR_W(32)) bus ();

  mem_byte_access #(.ADDR_W(32)) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .rdy_in        (rdy),
    .flush_in      (flush),
    .io_buffer_full(iofull),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Fixed RAM contents with one-cycle registered read.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h0000_1000: ram_rd = 8'h78;
      32'h0000_1001: ram_rd = 8'h56;
      32'h0000_1002: ram_rd = 8'h34;
      32'h0000_1003: ram_rd = 8'h12;
      32'h0000_0003: ram_rd = 8'h80;
      32'hFFFF_FFFF: ram_rd = 8'hA5;
      32'h0000_0000: ram_rd = 8'h3C;
      default:       ram_rd = a[7:0] + 8'h11;
    endcase
  endfunction

  always @(posedge clk) bus.mem_din <= ram_rd(bus.mem_a);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request in cycle A; returns at the negedge of cycle A+1.
  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    $display("issue type=%0d addr=%h wdata=%h", t, a, wd);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_type  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    step();
    step();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_dout", bus.mem_dout, 0);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_done_valid", bus.done_valid, 0);
    chk("rst_done_type", bus.done_type, 0);
    chk("rst_done_data", bus.done_data, 0);
    rst_n = 1'b1;
    step();

    // LW 0x1000: addresses A+1..A+4, done at A+6.
    issue(LW, 32'h1000, 0);
    chk("lw_ready_busy", bus.req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      chk("lw_mem_a", bus.mem_a, 32'h1000 + k);
      chk("lw_wr", bus.mem_wr, 0);
      chk("lw_no_done", bus.done_valid, 0);
      step();
    end
    chk("lw_no_done_a5", bus.done_valid, 0);
    step();
    chk("lw_done", bus.done_valid, 1);
    chk("lw_data", bus.done_data, 32'h1234_5678);
    chk("lw_type", bus.done_type, LW);
    step();
    chk("lw_pulse_end", bus.done_valid, 0);
    chk("lw_ready_back", bus.req_ready, 1);

    // LB 0x3: done at A+3, upper bytes zero.
    issue(LB, 32'h3, 0);
    chk("lb_mem_a", bus.mem_a, 32'h3);
    step();
    chk("lb_no_done", bus.done_valid, 0);
    step();
    chk("lb_done", bus.done_valid, 1);
    chk("lb_data", bus.done_data, 32'h0000_0080);
    chk("lb_type", bus.done_type, LB);
    step();

    // SH 0x10: two writes, done at A+3 with zero data.
    issue(SH, 32'h10, 32'hDEAD_BEEF);
    chk("sh_wr0", bus.mem_wr, 1);
    chk("sh_a0", bus.mem_a, 32'h10);
    chk("sh_d0", bus.mem_dout, 8'hEF);
    step();
    chk("sh_wr1", bus.mem_wr, 1);
    chk("sh_a1", bus.mem_a, 32'h11);
    chk("sh_d1", bus.mem_dout, 8'hBE);
    step();
    chk("sh_done", bus.done_valid, 1);
    chk("sh_data", bus.done_data, 0);
    chk("sh_type", bus.done_type, SH);
    chk("sh_wr_off", bus.mem_wr, 0);
    step();

    // LH at top of address space wraps to 0.
    issue(LH, 32'hFFFF_FFFF, 0);
    chk("lh_a0", bus.mem_a, 32'hFFFF_FFFF);
    step();
    chk("lh_a1_wrap", bus.mem_a, 32'h0);
    step();
    step();
    chk("lh_done", bus.done_valid, 1);
    chk("lh_data", bus.done_data, 32'h0000_3CA5);
    step();

    // LW with 3-cycle pause starting at A+3: done moves from A+6 to A+9.
    issue(LW, 32'h1000, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      rdy = 1'b0;
      chk("pause_mem_a", bus.mem_a, 32'h1002);
      chk("pause_wr", bus.mem_wr, 0);
      chk("pause_no_done", bus.done_valid, 0);
    end
    step();
    rdy = 1'b1;
    chk("pause_resume_a", bus.mem_a, 32'h1002);
    step();
    step();
    chk("pause_no_done_a8", bus.done_valid, 0);
    step();
    chk("pause_done", bus.done_valid, 1);
    chk("pause_data", bus.done_data, 32'h1234_5678);
    step();

    // LW flushed at A+2: no completion, ready at A+3.
    issue(LW, 32'h1000, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ld_ready", bus.req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk("flush_ld_no_done", bus.done_valid, 0);
      step();
    end

    // SW flushed at A+2: all four writes still happen, done at A+5.
    issue(SW, 32'h20, 32'h1122_3344);
    chk("sw_d0", bus.mem_dout, 8'h44);
    step();
    flush = 1'b1;
    chk("sw_a1", bus.mem_a, 32'h21);
    chk("sw_d1", bus.mem_dout, 8'h33);
    step();
    flush = 1'b0;
    chk("sw_wr2", bus.mem_wr, 1);
    chk("sw_d2", bus.mem_dout, 8'h22);
    step();
    chk("sw_a3", bus.mem_a, 32'h23);
    chk("sw_d3", bus.mem_dout, 8'h11);
    step();
    chk("sw_done", bus.done_valid, 1);
    chk("sw_type", bus.done_type, SW);
    step();

    // Unrecognised type: done at A+1, no RAM write.
    issue(4'hF, 32'h44, 32'hFFFF_FFFF);
    chk("bad_done", bus.done_valid, 1);
    chk("bad_data", bus.done_data, 0);
    chk("bad_type", bus.done_type, 4'hF);
    chk("bad_wr", bus.mem_wr, 0);
    step();

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    issue(SB, 32'h50, 32'h99);
    flush = 1'b0;
    chk("idle_flush_ready", bus.req_ready, 1);
    chk("idle_flush_wr", bus.mem_wr, 0);
    step();

    // SB to the I/O region while the UART buffer is full.
    iofull = 1'b1;
    issue(SB, 32'h0003_0000, 32'h5A);
`ifdef IO_STALL_EN
    chk("io_wr", bus.mem_wr, 0);
`else
    chk("io_wr", bus.mem_wr, 1);
`endif
    iofull = 1'b0;
    step();
    step();
    step();

    // Reset mid-load abandons it without a done pulse.
    issue(LW, 32'h1000, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rst_mid_no_done", bus.done_valid, 0);
      step();
    end
    chk("rst_mid_ready", bus.req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
